// File: rtl/ccip_arb_pkg.sv
// Shared types and helpers for the CCI-P channel arbiters: mdata packing and
// the round-robin search used by rr_grant.
package ccip_arb_pkg;

  localparam int unsigned CL_ADDR_W   = 42;
  localparam int unsigned MDATA_W     = 16;
  localparam int unsigned CL_DATA_W   = 512;
  localparam int unsigned MAX_CLIENTS = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Client id sits in the top id_bits of mdata, the tag fills the rest.
  function automatic logic [MDATA_W-1:0] pack_mdata(
    input logic [2:0]         id,
    input logic [MDATA_W-1:0] tag,
    input int unsigned        id_bits
  );
    logic [MDATA_W-1:0] tag_mask;
    tag_mask   = (16'd1 << (MDATA_W - id_bits)) - 16'd1;
    pack_mdata = (MDATA_W'(id) << (MDATA_W - id_bits)) | (tag & tag_mask);
  endfunction

  function automatic logic [2:0] unpack_id(
    input logic [MDATA_W-1:0] mdata,
    input int unsigned        id_bits
  );
    unpack_id = 3'(mdata >> (MDATA_W - id_bits));
  endfunction

  // First set bit of valid_vec at or after ptr, wrapping within n entries.
  function automatic rr_pick_t find_next_rr(
    input logic [MAX_CLIENTS-1:0] valid_vec,
    input logic [2:0]             ptr,
    input int unsigned            n
  );
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_CLIENTS; k++) begin
      if (k < n && !r.found) begin
        j = (32'(ptr) + k) % n;
        if (valid_vec[j]) begin
          r.found = 1'b1;
          r.idx   = 3'(j);
        end
      end
    end
    find_next_rr = r;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Parameterized round-robin picker; owns the rotating priority pointer.
module rr_grant
  import ccip_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] rr_ptr;
  rr_pick_t      pick;

  always_comb begin
    pick      = find_next_rr(MAX_CLIENTS'(req), 3'(rr_ptr), N);
    gnt_valid = pick.found;
    gnt_idx   = pick.idx[IW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_valid) begin
      rr_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/ccip_c0_rr_arbiter.sv
// CCI-P c0 read-request arbiter: round-robin grant with per-client credits,
// registered issue to MPF, and mdata-routed response return.
module ccip_c0_rr_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS     = 4,
  parameter int unsigned ID_BITS         = $clog2(NUM_CLIENTS),
  parameter int unsigned TAG_BITS        = 16 - ID_BITS,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CLIENTS-1:0]          client_rd_valid,
  input  logic [NUM_CLIENTS*42-1:0]       client_rd_addr,
  input  logic [NUM_CLIENTS*TAG_BITS-1:0] client_rd_tag,
  output logic [NUM_CLIENTS-1:0]          client_rd_ready,
  output logic [NUM_CLIENTS-1:0]          client_rsp_valid,
  output logic [511:0]                    client_rsp_data,
  output logic [TAG_BITS-1:0]             client_rsp_tag,
  output logic                            c0_tx_valid,
  output logic [41:0]                     c0_tx_addr,
  output logic [15:0]                     c0_tx_mdata,
  input  logic                            c0_tx_alm_full,
  input  logic                            c0_rx_rd_valid,
  input  logic [511:0]                    c0_rx_data,
  input  logic [15:0]                     c0_rx_mdata,
  output logic [NUM_CLIENTS*CNT_W-1:0]    outstanding,
  output logic                            err_bad_id
);

  logic [CNT_W-1:0]       count [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] eligible;
  logic                   gnt_valid;
  logic [ID_BITS-1:0]     gnt_idx;
  logic [CL_ADDR_W-1:0]   sel_addr;
  logic [TAG_BITS-1:0]    sel_tag;
  logic [ID_BITS-1:0]     rx_id;
  logic [NUM_CLIENTS-1:0] rx_hit;
  logic                   rx_bad;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      eligible[i] = client_rd_valid[i] && (count[i] < CNT_W'(MAX_OUTSTANDING))
                    && !c0_tx_alm_full && !reset;
    end
  end

  rr_grant #(.N(NUM_CLIENTS)) u_rr_grant (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    client_rd_ready = '0;
    sel_addr        = '0;
    sel_tag         = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt_idx == ID_BITS'(i)) begin
        client_rd_ready[i] = gnt_valid;
        sel_addr           = client_rd_addr[i*CL_ADDR_W +: CL_ADDR_W];
        sel_tag            = client_rd_tag[i*TAG_BITS +: TAG_BITS];
      end
    end
  end

  // Ids beyond NUM_CLIENTS match no client and are flagged instead of routed.
  always_comb begin
    rx_id = ID_BITS'(unpack_id(c0_rx_mdata, ID_BITS));
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      rx_hit[i] = c0_rx_rd_valid && (rx_id == ID_BITS'(i));
    end
    rx_bad = c0_rx_rd_valid && !(|rx_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c0_tx_valid <= 1'b0;
      c0_tx_addr  <= '0;
      c0_tx_mdata <= '0;
    end else begin
      c0_tx_valid <= gnt_valid;
      if (gnt_valid) begin
        c0_tx_addr  <= sel_addr;
        c0_tx_mdata <= pack_mdata(3'(gnt_idx), MDATA_W'(sel_tag), ID_BITS);
      end
    end
  end

  // A same-cycle grant and response cancel; a lone response saturates at zero.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (reset) begin
        count[i] <= '0;
      end else if (client_rd_ready[i] && !rx_hit[i]) begin
        count[i] <= count[i] + CNT_W'(1);
      end else if (!client_rd_ready[i] && rx_hit[i] && count[i] != '0) begin
        count[i] <= count[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      client_rsp_valid <= '0;
      client_rsp_data  <= '0;
      client_rsp_tag   <= '0;
      err_bad_id       <= 1'b0;
    end else begin
      client_rsp_valid <= rx_hit;
      if (|rx_hit) begin
        client_rsp_data <= c0_rx_data;
        client_rsp_tag  <= c0_rx_mdata[TAG_BITS-1:0];
      end
      if (rx_bad) begin
        err_bad_id <= 1'b1;
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      outstanding[i*CNT_W +: CNT_W] = count[i];
    end
  end

endmodule

// File: tb/tb_ccip_c0_rr_arbiter.sv
// Scoreboard bench for ccip_c0_rr_arbiter: random traffic against a queue-based
// reference model, plus a 3-client instance for out-of-range response ids.
module tb_ccip_c0_rr_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   client_rd_valid = '0;
  logic [167:0] client_rd_addr = '0;
  logic [55:0]  client_rd_tag = '0;
  logic [3:0]   client_rd_ready;
  logic [3:0]   client_rsp_valid;
  logic [511:0] client_rsp_data;
  logic [13:0]  client_rsp_tag;
  logic         c0_tx_valid;
  logic [41:0]  c0_tx_addr;
  logic [15:0]  c0_tx_mdata;
  logic         c0_tx_alm_full = 1'b0;
  logic         c0_rx_rd_valid = 1'b0;
  logic [511:0] c0_rx_data = '0;
  logic [15:0]  c0_rx_mdata = '0;
  logic [27:0]  outstanding;
  logic         err_bad_id;

  logic         reset3 = 1'b1;
  logic [2:0]   v3 = '0;
  logic [125:0] a3 = '0;
  logic [41:0]  t3 = '0;
  logic [2:0]   rdy3, rspv3;
  logic [511:0] rspd3;
  logic [13:0]  rspt3;
  logic         txv3;
  logic [41:0]  txa3;
  logic [15:0]  txm3;
  logic         rxv3 = 1'b0;
  logic [511:0] rxd3 = '0;
  logic [15:0]  rxm3 = '0;
  logic [20:0]  out3;
  logic         err3;

  always #5 clk = ~clk;

  ccip_c0_rr_arbiter #(.NUM_CLIENTS(4)) dut (
    .clk(clk), .reset(reset),
    .client_rd_valid(client_rd_valid), .client_rd_addr(client_rd_addr),
    .client_rd_tag(client_rd_tag), .client_rd_ready(client_rd_ready),
    .client_rsp_valid(client_rsp_valid), .client_rsp_data(client_rsp_data),
    .client_rsp_tag(client_rsp_tag),
    .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
    .c0_tx_alm_full(c0_tx_alm_full), .c0_rx_rd_valid(c0_rx_rd_valid),
    .c0_rx_data(c0_rx_data), .c0_rx_mdata(c0_rx_mdata),
    .outstanding(outstanding), .err_bad_id(err_bad_id)
  );

  ccip_c0_rr_arbiter #(.NUM_CLIENTS(3)) dut3 (
    .clk(clk), .reset(reset3),
    .client_rd_valid(v3), .client_rd_addr(a3), .client_rd_tag(t3),
    .client_rd_ready(rdy3), .client_rsp_valid(rspv3), .client_rsp_data(rspd3),
    .client_rsp_tag(rspt3),
    .c0_tx_valid(txv3), .c0_tx_addr(txa3), .c0_tx_mdata(txm3),
    .c0_tx_alm_full(1'b0), .c0_rx_rd_valid(rxv3), .c0_rx_data(rxd3),
    .c0_rx_mdata(rxm3), .outstanding(out3), .err_bad_id(err3)
  );

  typedef struct {
    logic [41:0] addr;
    logic [15:0] mdata;
  } tx_t;

  typedef struct {
    logic [3:0]   oh;
    logic [13:0]  tag;
    logic [511:0] data;
  } rsp_t;

  tx_t  txq[$];
  rsp_t rspq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: in-flight reads per client and next round-robin start.
  int unsigned mcnt[4];
  int unsigned mptr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  tx_t  te;
  rsp_t re;

  always @(posedge clk) begin
    #1;
    if (c0_tx_valid) begin
      checks++;
      if (txq.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got addr %h mdata %h expected no request", c0_tx_addr, c0_tx_mdata);
      end else begin
        te = txq.pop_front();
        if (c0_tx_addr !== te.addr || c0_tx_mdata !== te.mdata) begin
          errors++;
          $display("FAIL tx_req: got addr %h mdata %h expected addr %h mdata %h",
                   c0_tx_addr, c0_tx_mdata, te.addr, te.mdata);
        end
      end
    end
    if (|client_rsp_valid) begin
      checks++;
      if (rspq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got valid %b expected none", client_rsp_valid);
      end else begin
        re = rspq.pop_front();
        if (client_rsp_valid !== re.oh || client_rsp_tag !== re.tag || client_rsp_data !== re.data) begin
          errors++;
          $display("FAIL rsp: got valid %b tag %h data %h expected valid %b tag %h data %h",
                   client_rsp_valid, client_rsp_tag, client_rsp_data, re.oh, re.tag, re.data);
        end
      end
    end
  end

  // One cycle of traffic: check settled state, drive inputs, predict, update model.
  task automatic step(input logic [3:0] vmask, input bit alm, input int rsp_pct, input int force_c);
    logic [41:0] ca[4];
    logic [13:0] ct[4];
    int          cand[$];
    int          rc;
    int          g;
    int          j;
    rsp_t        r;
    tx_t         t;
    @(negedge clk);
    for (int c = 0; c < 4; c++)
      chk($sformatf("outstanding%0d", c), 64'(outstanding[c*7 +: 7]), 64'(mcnt[c]));
    chk("tx_pending", 64'(txq.size()), 64'd0);
    chk("rsp_pending", 64'(rspq.size()), 64'd0);
    chk("err_bad_id", 64'(err_bad_id), 64'd0);
    for (int c = 0; c < 4; c++) begin
      ca[c] = 42'({$urandom, $urandom});
      ct[c] = 14'($urandom);
      client_rd_addr[c*42 +: 42] = ca[c];
      client_rd_tag[c*14 +: 14]  = ct[c];
    end
    client_rd_valid = vmask;
    c0_tx_alm_full  = alm;
    c0_rx_rd_valid  = 1'b0;
    rc = -1;
    for (int c = 0; c < 4; c++) if (mcnt[c] > 0) cand.push_back(c);
    if (force_c >= 0) rc = force_c;
    else if (cand.size() > 0 && $urandom_range(99) < 32'(rsp_pct))
      rc = cand[$urandom_range(cand.size() - 1)];
    if (rc >= 0) begin
      r.oh   = 4'b0001 << rc;
      r.tag  = (force_c >= 0) ? 14'h0A5 : 14'($urandom);
      r.data = rand_line();
      c0_rx_rd_valid = 1'b1;
      c0_rx_mdata    = {2'(rc), r.tag};
      c0_rx_data     = r.data;
      rspq.push_back(r);
    end
    #1;
    g = -1;
    if (!alm) begin
      for (int k = 0; k < 4; k++) begin
        j = (int'(mptr) + k) % 4;
        if (g < 0 && vmask[j] && mcnt[j] < 64) g = j;
      end
    end
    chk("rd_ready", 64'(client_rd_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (g >= 0) begin
      t.addr  = ca[g];
      t.mdata = {2'(g), ct[g]};
      txq.push_back(t);
      mptr = 32'((g + 1) % 4);
    end
    for (int c = 0; c < 4; c++) begin
      if (g == c && rc != c) mcnt[c]++;
      else if (g != c && rc == c && mcnt[c] > 0) mcnt[c]--;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    client_rd_valid = '1;
    c0_rx_rd_valid  = 1'b0;
    c0_tx_alm_full  = 1'b0;
    #1 chk("ready_in_reset", 64'(client_rd_ready), 64'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("ready_in_reset", 64'(client_rd_ready), 64'd0);
      chk("tx_valid_rst", 64'(c0_tx_valid), 64'd0);
      chk("tx_addr_rst", 64'(c0_tx_addr), 64'd0);
      chk("tx_mdata_rst", 64'(c0_tx_mdata), 64'd0);
      chk("rsp_valid_rst", 64'(client_rsp_valid), 64'd0);
      chk("rsp_data_rst", 64'(client_rsp_data != '0), 64'd0);
      chk("rsp_tag_rst", 64'(client_rsp_tag), 64'd0);
      chk("err_rst", 64'(err_bad_id), 64'd0);
      chk("outstanding_rst", 64'(outstanding), 64'd0);
    end
    for (int c = 0; c < 4; c++) mcnt[c] = 0;
    mptr = 0;
    txq.delete();
    rspq.delete();
    reset = 1'b0;
    client_rd_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned  sum;
    logic [511:0] d3;
    for (int c = 0; c < 4; c++) mcnt[c] = 0;
    mptr = 0;
    do_reset(3);

    repeat (8)   step(4'hF, 1'b0, 0, -1);
    repeat (10)  step(4'hF, 1'b1, 0, -1);
    repeat (4)   step(4'hF, 1'b0, 0, -1);
    repeat (400) step(4'($urandom), $urandom_range(9) < 2, 40, -1);

    do_reset(2);
    repeat (70) step(4'b0100, 1'b0, 0, -1);
    repeat (8)  step(4'hF, 1'b0, 0, -1);
    step(4'hF, 1'b0, 0, 2);
    repeat (6)  step(4'hF, 1'b0, 0, -1);
    repeat (300) step(4'($urandom), $urandom_range(9) < 1, 60, -1);

    sum = 1;
    for (int it = 0; it < 400 && sum > 0; it++) begin
      step(4'h0, 1'b0, 100, -1);
      sum = 0;
      for (int c = 0; c < 4; c++) sum += mcnt[c];
    end
    chk("drain", 64'(sum), 64'd0);
    step(4'h0, 1'b0, 0, -1);

    @(negedge clk);
    reset3 = 1'b0;
    chk("n3_err_init", 64'(err3), 64'd0);
    rxv3 = 1'b1;
    rxm3 = 16'hC0A5;
    rxd3 = rand_line();
    @(negedge clk);
    rxv3 = 1'b0;
    chk("n3_badid_rspv", 64'(rspv3), 64'd0);
    chk("n3_badid_err", 64'(err3), 64'd1);
    chk("n3_badid_cnt", 64'(out3), 64'd0);
    v3 = 3'b001;
    t3[13:0] = 14'h0055;
    a3[41:0] = 42'h123_4567_89AB;
    #1 chk("n3_ready", 64'(rdy3), 64'd1);
    @(negedge clk);
    v3 = '0;
    chk("n3_tx_valid", 64'(txv3), 64'd1);
    chk("n3_tx_mdata", 64'(txm3), 64'h0055);
    chk("n3_tx_addr", 64'(txa3), 64'h123_4567_89AB);
    chk("n3_cnt1", 64'(out3), 64'd1);
    chk("n3_err_sticky", 64'(err3), 64'd1);
    d3 = rand_line();
    rxv3 = 1'b1;
    rxm3 = 16'h0055;
    rxd3 = d3;
    @(negedge clk);
    rxv3 = 1'b0;
    chk("n3_rspv", 64'(rspv3), 64'd1);
    chk("n3_rspt", 64'(rspt3), 64'h0055);
    chk("n3_rspd", 64'(rspd3 == d3), 64'd1);
    chk("n3_cnt0", 64'(out3), 64'd0);
    chk("n3_err_held", 64'(err3), 64'd1);
    reset3 = 1'b1;
    @(negedge clk);
    chk("n3_err_rst", 64'(err3), 64'd0);
    chk("n3_rspv_rst", 64'(rspv3), 64'd0);
    chk("n3_tx_rst", 64'(txv3), 64'd0);

    chk("tx_queue_empty", 64'(txq.size()), 64'd0);
    chk("rsp_queue_empty", 64'(rspq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccip_c0_rr_arbiter.md
# ccip_c0_rr_arbiter

Shares the CCI-P read-request channel (c0Tx) among NUM_CLIENTS engine read ports behind the MPF-wrapped AFU boundary, and routes read responses (c0Rx) back to the issuing client. Round-robin arbitration, per-client outstanding-request credits, and back-pressure from c0TxAlmFull. The client index is carried in the upper mdata bits. Sits inside the AFU arbiter layer, between the compute engines and the CCI-P Tx/Rx structures.

## Interface
- NUM_CLIENTS, 4: number of read clients, 2..8.
- ID_BITS, $clog2(NUM_CLIENTS): client index width, stored in mdata[15:16-ID_BITS].
- TAG_BITS, 16-ID_BITS: client-private tag width, stored in mdata[TAG_BITS-1:0].
- MAX_OUTSTANDING, 64: per-client in-flight read limit; counter width CNT_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- client_rd_valid  in  NUM_CLIENTS  read request pending, one bit per client.
- client_rd_addr  in  NUM_CLIENTS*42  cache-line address, client i at [42*i +: 42].
- client_rd_tag  in  NUM_CLIENTS*TAG_BITS  client tag, returned with the response.
- client_rd_ready  out  NUM_CLIENTS  request accepted this cycle (one-hot or zero).
- client_rsp_valid  out  NUM_CLIENTS  response for client i (one-hot or zero).
- client_rsp_data  out  512  response line, shared by all clients.
- client_rsp_tag  out  TAG_BITS  tag of the response.
- c0_tx_valid  out  1  read request to MPF.
- c0_tx_addr  out  42  request address.
- c0_tx_mdata  out  16  {client id, tag}.
- c0_tx_alm_full  in  1  MPF c0TxAlmFull.
- c0_rx_rd_valid  in  1  read response valid.
- c0_rx_data  in  512  response data.
- c0_rx_mdata  in  16  response mdata.
- outstanding  out  NUM_CLIENTS*CNT_W  per-client in-flight count.
- err_bad_id  out  1  sticky: a response arrived with an id >= NUM_CLIENTS.

## Operation
- Eligibility of client i: client_rd_valid[i], count[i] < MAX_OUTSTANDING, and c0_tx_alm_full low.
- Grant: the first eligible client at or after rr_ptr, with wrap. client_rd_ready[grant] is combinational in the same cycle. Handshake completes on valid&ready.
- After a grant to i, rr_ptr <= (i+1) mod NUM_CLIENTS. With no grant, rr_ptr holds.
- The issue register captures addr and {i, tag}. c0_tx_valid is high for exactly one cycle per grant. Back-to-back grants are allowed every cycle.
- On grant, count[i] increments.
- On c0_rx_rd_valid with id = c0_rx_mdata[15:16-ID_BITS] < NUM_CLIENTS:
  - count[id] decrements, saturating at 0 so responses straggling past a reset are harmless.
  - The response is registered to the client outputs.
- Grant and response for the same client in the same cycle: count is unchanged.
- On id >= NUM_CLIENTS (only possible when NUM_CLIENTS is not a power of two): the response is dropped, no counter changes, and err_bad_id is set until reset.
- Reset, values at the first cycle after reset:
  - rr_ptr=0, all counts=0, c0_tx_valid=0, c0_tx_addr=0, c0_tx_mdata=0.
  - client_rsp_valid=0, client_rsp_data=0, client_rsp_tag=0, err_bad_id=0.
  - client_rd_ready=0 while reset is high.
- Reset mid-operation discards in-flight accounting. Requests in the issue register are dropped.

## Timing
- Request latency: 1 cycle from the client handshake to c0_tx_valid.
- Response latency: 1 cycle from c0_rx_rd_valid to client_rsp_valid.
- c0_tx_alm_full gates grants in the cycle it is sampled high. The issue register may still emit the request granted in the prior cycle, which is within the MPF almost-full slack.
- The credit check uses the registered count. A client at MAX_OUTSTANDING-1 that is granted becomes ineligible on the next cycle.
- Throughput: 1 request/cycle aggregate, 1 response/cycle.

## Structure
- Package ccip_arb_pkg holds:
  - CL_ADDR_W=42, MDATA_W=16, CL_DATA_W=512.
  - A function to pack and unpack {id, tag} into mdata.
  - A function find_next_rr(valid_vec, ptr) returning the grant index and a found flag.
- One sub-module: rr_grant (a parameterized round-robin picker holding rr_ptr), reusable later for the c1Tx write arbiter.

## Test plan
- All 4 clients valid continuously, no alm_full: grants follow 0,1,2,3,0,…; c0_tx_mdata[15:14] follows the same sequence; each count reaches 1 after 4 cycles.
- Client 2 issues 64 reads with no responses: the 65th request is stalled (ready=0) while clients 0, 1 and 3 still get grants. One response with mdata id 2 re-enables client 2 on the following cycle.
- c0_tx_alm_full high for 10 cycles with all clients valid: zero grants during the window. At most one c0_tx_valid appears after the rise. Round-robin resumes at the held rr_ptr.
- Response mdata=16'h8_0A5 (id 2, tag 0x0A5) with data pattern: one cycle later client_rsp_valid=4'b0100, client_rsp_tag=0x0A5, data matches.
- Same-cycle grant and response for client 1 with count=5: count stays 5.
- NUM_CLIENTS=3, response with id 3: no rsp_valid, counts unchanged, err_bad_id=1 until reset. Asserting reset mid-burst clears every output to the reset values listed above.
